// File: rtl/serial_frame_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// Holds the FSM state encoding, line levels and parity helper.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        GAP
    } state_t;

    localparam logic IDLE_LEVEL = 1'b0;
    localparam logic START_BIT  = 1'b1;
    localparam int   MAX_W      = 64;

    // Zero-extended words keep the same XOR, so one width serves all.
    function automatic logic even_parity(input logic [MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake between a producer and the serial frame transmitter.
// The master offers in_data/in_valid; the slave answers with in_ready.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Framing transmitter: start bit, MSB-first data, optional even parity,
// then an idle gap; feeds the si input of a downstream shift chain.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clear_n,
    serial_frame_tx_if.slave  up,
    output logic              so,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_PEN  = BW'(DATA_W - 2);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t AFTER_PAR =
        (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam state_t AFTER_DATA =
        (PARITY_EN != 0) ? PARITY : AFTER_PAR;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] shift_reg;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              parity_bit;
    logic              accept;
    logic              so_d;
    logic              busy_d;
    logic              done_d;
    logic              ready_d;

    assign accept = up.in_ready & up.in_valid;

    // Outputs are registered from next_state so they line up with state.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            parity_bit  <= 1'b0;
            so          <= IDLE_LEVEL;
            busy        <= 1'b0;
            done        <= 1'b0;
            up.in_ready <= 1'b0;
        end else begin
            state       <= next_state;
            so          <= so_d;
            busy        <= busy_d;
            done        <= done_d;
            up.in_ready <= ready_d;
            if (accept) begin
                shift_reg  <= up.in_data;
                parity_bit <= even_parity(MAX_W'(up.in_data));
            end else if (next_state == DATA) begin
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            end
            if (state == DATA && next_state == DATA) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end
            if (state == GAP && next_state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (accept) next_state = START;
            START:  next_state = DATA;
            DATA:   if (bit_cnt == BIT_LAST) next_state = AFTER_DATA;
            PARITY: next_state = AFTER_PAR;
            GAP:    if (gap_cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        so_d    = IDLE_LEVEL;
        done_d  = 1'b0;
        busy_d  = (next_state != IDLE);
        ready_d = (next_state == IDLE);
        unique case (next_state)
            START: so_d = START_BIT;
            DATA: begin
                so_d   = shift_reg[DATA_W-1];
                done_d = (PARITY_EN == 0) && (state == DATA)
                         && (bit_cnt == BIT_PEN);
            end
            PARITY: begin
                so_d   = parity_bit;
                done_d = 1'b1;
            end
            default: so_d = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: default and no-parity/no-gap
// builds, plus a 4-deep shift chain fed by the default build's so.
module tb_serial_frame_tx;
    import serial_pkg::*;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(8)) ifc1 ();
    serial_frame_tx_if #(.DATA_W(8)) ifc2 ();

    logic so1, busy1, done1;
    logic so2, busy2, done2;

    serial_frame_tx u_dut1 (
        .clk(clk), .clear_n(clear_n), .up(ifc1),
        .so(so1), .busy(busy1), .done(done1)
    );

    serial_frame_tx #(.PARITY_EN(0), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .clear_n(clear_n), .up(ifc2),
        .so(so2), .busy(busy2), .done(done2)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream serial-in/serial-out shift register, depth 4.
    logic [3:0] ds_sr;
    always @(posedge clk) begin
        if (!clear_n) ds_sr <= '0;
        else          ds_sr <= {ds_sr[2:0], so1};
    end

    logic [1:0] q1[$];
    logic [1:0] q2[$];
    logic [1:0] e1, e2;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy1 === 1'b1) begin
            if (q1.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL dut1 extra bit: got so=%b, expected none", so1);
            end else begin
                e1 = q1.pop_front();
                check("dut1 so", 32'(so1), 32'(e1[1]));
                check("dut1 done", 32'(done1), 32'(e1[0]));
            end
        end else begin
            check("dut1 idle so", 32'(so1), 32'(IDLE_LEVEL));
            check("dut1 idle done", 32'(done1), 32'd0);
        end
        if (busy2 === 1'b1) begin
            if (q2.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL dut2 extra bit: got so=%b, expected none", so2);
            end else begin
                e2 = q2.pop_front();
                check("dut2 so", 32'(so2), 32'(e2[1]));
                check("dut2 done", 32'(done2), 32'(e2[0]));
            end
        end else begin
            check("dut2 idle so", 32'(so2), 32'(IDLE_LEVEL));
            check("dut2 idle done", 32'(done2), 32'd0);
        end
    end

    task automatic push(input int which, input logic [15:0] seq,
                        input int len, input int didx, input int n);
        logic [1:0] v;
        for (int i = 0; i < n; i++) begin
            v = {seq[len-1-i], 1'(i == didx)};
            if (which == 1) q1.push_back(v);
            else            q2.push_back(v);
        end
    endtask

    task automatic send(input int which, input logic [7:0] d,
                        input logic hold, output int t);
        if (which == 1) begin
            ifc1.in_data = d; ifc1.in_valid = 1'b1;
        end else begin
            ifc2.in_data = d; ifc2.in_valid = 1'b1;
        end
        t = -1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if ((which == 1) ? ifc1.in_ready : ifc2.in_ready) begin
                t = cyc;
                break;
            end
        end
        #1;
        if (!hold) begin
            if (which == 1) ifc1.in_valid = 1'b0;
            else            ifc2.in_valid = 1'b0;
        end
        if (t < 0) begin
            nvec++; nerr++;
            $display("FAIL accept timeout dut%0d: got none, expected accept", which);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] a5seq;
    logic        dexp;
    int ta, tb;

    initial begin
        a5seq = 16'(11'b1_10100101_0_0);
        ifc1.in_data = '0; ifc1.in_valid = 1'b0;
        ifc2.in_data = '0; ifc2.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset so", 32'(so1), 32'd0);
        check("reset busy", 32'(busy1), 32'd0);
        check("reset done", 32'(done1), 32'd0);
        check("reset ready", 32'(ifc1.in_ready), 32'd0);
        clear_n = 1'b1;
        @(negedge clk);
        check("ready after reset", 32'(ifc1.in_ready), 32'd1);

        // A5 with parity 0 and one gap cycle
        push(1, a5seq, 11, 9, 11);
        send(1, 8'hA5, 1'b0, ta);
        repeat (11) @(negedge clk);
        check("t1 ready low c11", 32'(ifc1.in_ready), 32'd0);
        @(negedge clk);
        check("t1 ready high c12", 32'(ifc1.in_ready), 32'd1);

        push(1, 16'(11'b1_00000111_1_0), 11, 9, 11);
        push(1, 16'(11'b1_00000000_0_0), 11, 9, 11);
        send(1, 8'h07, 1'b0, ta);
        send(1, 8'h00, 1'b0, ta);

        // back-to-back with in_valid held; data swapped while busy
        push(1, 16'(11'b1_00111100_0_0), 11, 9, 11);
        push(1, 16'(11'b1_11000011_0_0), 11, 9, 11);
        send(1, 8'h3C, 1'b1, ta);
        send(1, 8'hC3, 1'b0, tb);
        check("t3 period", 32'(tb - ta), 32'd12);
        repeat (12) @(negedge clk);

        // abort during the 4th data bit
        push(1, a5seq, 11, 9, 5);
        send(1, 8'hA5, 1'b0, ta);
        repeat (4) @(posedge clk);
        #1 clear_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4 so", 32'(so1), 32'd0);
        check("t4 busy", 32'(busy1), 32'd0);
        check("t4 done", 32'(done1), 32'd0);
        check("t4 ready", 32'(ifc1.in_ready), 32'd0);
        clear_n = 1'b1;
        @(negedge clk);
        check("t4 ready after release", 32'(ifc1.in_ready), 32'd1);

        // no parity, no gap
        push(2, 16'(9'b1_10000001), 9, 8, 9);
        push(2, 16'(9'b1_01011010), 9, 8, 9);
        send(2, 8'h81, 1'b1, ta);
        send(2, 8'h5A, 1'b0, tb);
        check("t5 period", 32'(tb - ta), 32'd10);
        repeat (12) @(negedge clk);

        // end-to-end through the downstream shift register
        push(1, a5seq, 11, 9, 11);
        send(1, 8'hA5, 1'b0, ta);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            dexp = (k <= 4) ? 1'b0 : a5seq[15-k];
            check("t6 downstream so", 32'(ds_sr[3]), 32'(dexp));
        end

        repeat (20) @(negedge clk);
        check("q1 drained", 32'(q1.size()), 32'd0);
        check("q2 drained", 32'(q2.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
